fir_xifu_mem_responder: RTL and testbench

Memory responder for the CV-X-IF memory interface of the FIR XIFU. It accepts `mem_req` transactions issued by the coprocessor EX stage (`xfirlw`/`xfirsw` traffic), returns the same-cycle `mem_resp`, and forwards each accepted request to a single OBI-style data port. It tracks outstanding transactions in an in-order ID FIFO and returns one registered `mem_result` per completed access. It stands in for the core LSU in standalone coprocessor benches and FPGA bring-up.

---
 rtl/fir_xifu_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_fir_xifu_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_mem_responder.sv
// fir_xifu_mem_responder
// Stand-in for the core LSU on the CV-X-IF memory interface of the FIR XIFU.
// Accepted mem_req transactions are forwarded to a single OBI data port.
// Outstanding accesses are tracked in an in-order ID FIFO, and one registered
// mem_result is returned per completed access.
//
// Build option: define FIR_XIFU_MEM_MISALIGN_CHECK_EN to enable misalignment
// detection and the synchronous exception path. Without it, every request is
// forwarded to OBI unchanged and mem_resp_exc_o/mem_resp_exccode_o are tied to 0.

module fir_xifu_mem_responder #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // X-IF memory request / response
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [X_ID_WIDTH-1:0] mem_req_id_i,
  input  logic [31:0]           mem_req_addr_i,
  input  logic                  mem_req_we_i,
  input  logic [3:0]            mem_req_be_i,
  input  logic [31:0]           mem_req_wdata_i,
  output logic                  mem_resp_exc_o,
  output logic [5:0]            mem_resp_exccode_o,
  // X-IF memory result
  output logic                  mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0] mem_result_id_o,
  output logic [31:0]           mem_result_rdata_o,
  output logic                  mem_result_err_o,
  // OBI data port
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [31:0]           obi_addr_o,
  output logic                  obi_we_o,
  output logic [3:0]            obi_be_o,
  output logic [31:0]           obi_wdata_o,
  input  logic                  obi_rvalid_i,
  input  logic [31:0]           obi_rdata_i,
  input  logic                  obi_err_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;

  // ID FIFO state
  logic [X_ID_WIDTH-1:0] fifo_id_q [MAX_OUTSTANDING];
  logic [X_ID_WIDTH-1:0] fifo_id_d [MAX_OUTSTANDING];
  logic                  fifo_we_q [MAX_OUTSTANDING];
  logic                  fifo_we_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Registered result
  logic                  res_valid_q, res_valid_d;
  logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [31:0]           res_rdata_q, res_rdata_d;
  logic                  res_err_q, res_err_d;

  logic misaligned;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic [X_ID_WIDTH-1:0] head_id;
  logic                  head_we;

  assign fifo_full  = (count_q == CNT_MAX);
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_id_q[rd_ptr_q];
  assign head_we    = fifo_we_q[rd_ptr_q];

  // Misalignment detection: only full-word accesses are checked
  always_comb begin
    misaligned = 1'b0;
`ifdef FIR_XIFU_MEM_MISALIGN_CHECK_EN
    misaligned = (mem_req_addr_i[1:0] != 2'b00) && (mem_req_be_i == 4'b1111);
`endif
  end

  // Request path: OBI request, X-IF ready and payload pass-through, all combinational
  always_comb begin
    obi_req_o   = mem_valid_i && !misaligned && !fifo_full;
    mem_ready_o = (mem_valid_i && misaligned) || (obi_req_o && obi_gnt_i);
    obi_addr_o  = mem_valid_i ? mem_req_addr_i  : '0;
    obi_we_o    = mem_valid_i && mem_req_we_i;
    obi_be_o    = mem_valid_i ? mem_req_be_i    : '0;
    obi_wdata_o = mem_valid_i ? mem_req_wdata_i : '0;
  end

  // Synchronous mem_resp: non-zero only in the handshake cycle of a misaligned request
  always_comb begin
    mem_resp_exc_o     = 1'b0;
    mem_resp_exccode_o = '0;
    if (mem_valid_i && mem_ready_o && misaligned) begin
      mem_resp_exc_o     = 1'b1;
      mem_resp_exccode_o = mem_req_we_i ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
    end
  end

  // FIFO control: push on OBI address handshake, pop on response while non-empty
  always_comb begin
    push = obi_req_o && obi_gnt_i;
    pop  = obi_rvalid_i && !fifo_empty;
  end

  // FIFO next state; a simultaneous push and pop leaves count unchanged
  always_comb begin
    fifo_id_d = fifo_id_q;
    fifo_we_d = fifo_we_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      fifo_id_d[wr_ptr_q] = mem_req_id_i;
      fifo_we_d[wr_ptr_q] = mem_req_we_i;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Result next state: one-cycle pulse carrying the popped head; stores return 0 data
  always_comb begin
    res_valid_d = pop;
    res_id_d    = pop ? head_id : '0;
    res_rdata_d = (pop && !head_we) ? obi_rdata_i : '0;
    res_err_d   = pop && obi_err_i;
  end

  // FIFO and result registers, flushed by the asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_id_q[i] <= '0;
        fifo_we_q[i] <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      fifo_id_q   <= fifo_id_d;
      fifo_we_q   <= fifo_we_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
    end
  end

  assign mem_result_valid_o = res_valid_q;
  assign mem_result_id_o    = res_id_q;
  assign mem_result_rdata_o = res_rdata_q;
  assign mem_result_err_o   = res_err_q;

`ifndef SYNTHESIS
  // Flag OBI responses that arrive with nothing outstanding; they are dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(obi_rvalid_i && fifo_empty))
        else $warning("fir_xifu_mem_responder: OBI rvalid with empty ID FIFO ignored");
    end
  end
`endif

endmodule

// File: tb/tb_fir_xifu_mem_responder.sv
// Scoreboard bench for fir_xifu_mem_responder (MAX_OUTSTANDING = 2).
// Expected results are queued as responses are issued; a negedge monitor
// pops and compares whenever mem_result_valid_o is high.

module tb_fir_xifu_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [3:0]  mem_req_id_i;
  logic [31:0] mem_req_addr_i;
  logic        mem_req_we_i;
  logic [3:0]  mem_req_be_i;
  logic [31:0] mem_req_wdata_i;
  logic        mem_resp_exc_o;
  logic [5:0]  mem_resp_exccode_o;
  logic        mem_result_valid_o;
  logic [3:0]  mem_result_id_o;
  logic [31:0] mem_result_rdata_o;
  logic        mem_result_err_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  fir_xifu_mem_responder #(
    .X_ID_WIDTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .mem_valid_i        (mem_valid_i),
    .mem_ready_o        (mem_ready_o),
    .mem_req_id_i       (mem_req_id_i),
    .mem_req_addr_i     (mem_req_addr_i),
    .mem_req_we_i       (mem_req_we_i),
    .mem_req_be_i       (mem_req_be_i),
    .mem_req_wdata_i    (mem_req_wdata_i),
    .mem_resp_exc_o     (mem_resp_exc_o),
    .mem_resp_exccode_o (mem_resp_exccode_o),
    .mem_result_valid_o (mem_result_valid_o),
    .mem_result_id_o    (mem_result_id_o),
    .mem_result_rdata_o (mem_result_rdata_o),
    .mem_result_err_o   (mem_result_err_o),
    .obi_req_o          (obi_req_o),
    .obi_gnt_i          (obi_gnt_i),
    .obi_addr_o         (obi_addr_o),
    .obi_we_o           (obi_we_o),
    .obi_be_o           (obi_be_o),
    .obi_wdata_o        (obi_wdata_o),
    .obi_rvalid_i       (obi_rvalid_i),
    .obi_rdata_i        (obi_rdata_i),
    .obi_err_i          (obi_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
  } res_t;

  typedef struct packed {
    logic [3:0] id;
    logic       we;
  } acc_t;

  res_t sb[$];     // expected results, in order
  acc_t model[$];  // accepted, still outstanding requests

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    mem_valid_i     = 1'b0;
    mem_req_id_i    = '0;
    mem_req_addr_i  = '0;
    mem_req_we_i    = 1'b0;
    mem_req_be_i    = '0;
    mem_req_wdata_i = '0;
    obi_gnt_i       = 1'b0;
    obi_rvalid_i    = 1'b0;
    obi_rdata_i     = '0;
    obi_err_i       = 1'b0;
  endtask

  // One clock cycle of stimulus; entered and left at posedge + 1.
  task automatic cyc(
    input logic        v,
    input logic [3:0]  id,
    input logic [31:0] addr,
    input logic        we,
    input logic [3:0]  be,
    input logic [31:0] wd,
    input logic        gnt,
    input logic        rv,
    input logic [31:0] rd,
    input logic        er,
    input logic        exp_rdy,
    input logic        exp_req,
    input logic        exp_exc,
    input logic [5:0]  exp_code
  );
    acc_t h;
    logic popped;
    mem_valid_i     = v;
    mem_req_id_i    = id;
    mem_req_addr_i  = addr;
    mem_req_we_i    = we;
    mem_req_be_i    = be;
    mem_req_wdata_i = wd;
    obi_gnt_i       = gnt;
    obi_rvalid_i    = rv;
    obi_rdata_i     = rd;
    obi_err_i       = er;
    @(negedge clk_i);
    chk("mem_ready", 32'(mem_ready_o), 32'(exp_rdy));
    chk("obi_req", 32'(obi_req_o), 32'(exp_req));
    chk("resp_exc", 32'(mem_resp_exc_o), 32'(exp_exc));
    chk("resp_exccode", 32'(mem_resp_exccode_o), 32'(exp_code));
    if (exp_req) begin
      chk("obi_addr", obi_addr_o, addr);
      chk("obi_we", 32'(obi_we_o), 32'(we));
      chk("obi_be", 32'(obi_be_o), 32'(be));
      chk("obi_wdata", obi_wdata_o, wd);
    end
    popped = 1'b0;
    if (rv && model.size() > 0) begin
      h = model.pop_front();
      sb.push_back('{id: h.id, rdata: (h.we ? 32'h0 : rd), err: er});
      popped = 1'b1;
    end
    if (v && exp_rdy && !exp_exc) model.push_back('{id: id, we: we});
    @(posedge clk_i);
    #1;
    clear_inputs();
    chk("result_latency", 32'(mem_result_valid_o), 32'(popped));
  endtask

  task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                     input logic [31:0] wd, input logic exp_rdy);
    cyc(1'b1, id, addr, we, 4'hF, wd, 1'b1, 1'b0, 32'h0, 1'b0, exp_rdy, exp_rdy, 1'b0, 6'd0);
  endtask

  task automatic rsp(input logic [31:0] rd, input logic er);
    cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, rd, er, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    model.delete();
    sb.delete();
    @(negedge clk_i);
    chk("rst_result_valid", 32'(mem_result_valid_o), 32'h0);
    chk("rst_result_id", 32'(mem_result_id_o), 32'h0);
    chk("rst_result_rdata", mem_result_rdata_o, 32'h0);
    chk("rst_result_err", 32'(mem_result_err_o), 32'h0);
    chk("rst_ready", 32'(mem_ready_o), 32'h0);
    chk("rst_obi_req", 32'(obi_req_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    res_t e;
    if (mem_result_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got id=%0d rdata=0x%08h, expected no result at %0t",
                 mem_result_id_o, mem_result_rdata_o, $time);
      end else begin
        e = sb.pop_front();
        chk("result_id", 32'(mem_result_id_o), 32'(e.id));
        chk("result_rdata", mem_result_rdata_o, e.rdata);
        chk("result_err", 32'(mem_result_err_o), 32'(e.err));
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk_i);
    #1;
    do_reset();

    // Single load: id 3, rvalid two cycles after the request
    req(4'd3, 32'h100, 1'b0, 32'h0, 1'b1);
    idle();
    rsp(32'hDEADBEEF, 1'b0);
    idle();

    // Store: id 5, result carries zero data
    req(4'd5, 32'h200, 1'b1, 32'h12345678, 1'b1);
    rsp(32'hFFFF0000, 1'b0);
    idle();

    // Grant withheld: request visible on OBI but not accepted, then granted
    cyc(1'b1, 4'd6, 32'h300, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
        1'b0, 1'b1, 1'b0, 6'd0);
    req(4'd6, 32'h300, 1'b0, 32'h0, 1'b1);
    rsp(32'h00C0FFEE, 1'b0);
    idle();

    // Back-pressure: ids 1,2 fill the FIFO; id 3 refused even with rvalid present
    req(4'd1, 32'h10, 1'b0, 32'h0, 1'b1);
    req(4'd2, 32'h14, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 4'd3, 32'h18, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'hA1, 1'b0,
        1'b0, 1'b0, 1'b0, 6'd0);
    req(4'd3, 32'h18, 1'b0, 32'h0, 1'b1);
    rsp(32'hA2, 1'b0);
    rsp(32'hA3, 1'b0);
    idle();

    // Simultaneous push and pop
    req(4'd4, 32'h40, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 4'd9, 32'h44, 1'b1, 4'hF, 32'h5555AAAA, 1'b1, 1'b1, 32'hB4, 1'b0,
        1'b1, 1'b1, 1'b0, 6'd0);
    rsp(32'hB9, 1'b0);
    idle();

    // Bus error: id 7
    req(4'd7, 32'h500, 1'b0, 32'h0, 1'b1);
    rsp(32'h55, 1'b1);
    idle();

    // Sub-word access at an unaligned address is never misaligned
    cyc(1'b1, 4'd8, 32'h103, 1'b0, 4'b0001, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
        1'b1, 1'b1, 1'b0, 6'd0);
    rsp(32'h000000AB, 1'b0);
    idle();

    // Full-word access at 0x102
`ifdef FIR_XIFU_MEM_MISALIGN_CHECK_EN
    cyc(1'b1, 4'd2, 32'h102, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
        1'b1, 1'b0, 1'b1, 6'd4);
    cyc(1'b1, 4'd2, 32'h102, 1'b1, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
        1'b1, 1'b0, 1'b1, 6'd6);
    idle();
    idle();
`else
    cyc(1'b1, 4'd2, 32'h102, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
        1'b1, 1'b1, 1'b0, 6'd0);
    cyc(1'b1, 4'd2, 32'h102, 1'b1, 4'hF, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0,
        1'b1, 1'b1, 1'b0, 6'd0);
    rsp(32'h11223344, 1'b0);
    rsp(32'h99999999, 1'b0);
    idle();
`endif

    // Reset mid-flight: two outstanding, reset, then stale responses are ignored
    req(4'd10, 32'h600, 1'b0, 32'h0, 1'b1);
    req(4'd11, 32'h604, 1'b0, 32'h0, 1'b1);
    do_reset();
    rsp(32'hBAD0, 1'b0);
    rsp(32'hBAD1, 1'b0);
    idle();
    // FIFO must be empty: exactly two new requests fit, the third is refused
    req(4'd12, 32'h700, 1'b0, 32'h0, 1'b1);
    req(4'd13, 32'h704, 1'b0, 32'h0, 1'b1);
    req(4'd14, 32'h708, 1'b0, 32'h0, 1'b0);
    rsp(32'hC12, 1'b0);
    rsp(32'hC13, 1'b0);
    idle();
    idle();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
